// File: rtl/acs_4state.sv
// Add-compare-select for the 4-state K=3 rate-1/2 Viterbi trellis (g0=7, g1=5).
// One step per bm_valid cycle, results registered 1 cycle later; no backpressure.
module acs_4state #(
  parameter int PM_W      = 8,
  parameter int INIT_BIAS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bm_valid,
  input  logic            frame_start,
  input  logic [1:0]      bm00,
  input  logic [1:0]      bm01,
  input  logic [1:0]      bm10,
  input  logic [1:0]      bm11,
  output logic            dec_valid,
  output logic [3:0]      decisions,
  output logic [PM_W-1:0] pm0,
  output logic [PM_W-1:0] pm1,
  output logic [PM_W-1:0] pm2,
  output logic [PM_W-1:0] pm3,
  output logic [1:0]      best_state,
  output logic            norm_flag
);

  localparam logic [PM_W-1:0] BIAS = PM_W'(INIT_BIAS);

  logic [3:0][PM_W-1:0] pm_q;
  logic [3:0][PM_W-1:0] old_pm;
  logic [3:0][PM_W-1:0] cand_u;
  logic [3:0][PM_W-1:0] cand_l;
  logic [3:0][PM_W-1:0] raw_pm;
  logic [3:0][PM_W-1:0] new_pm;
  logic [3:0]           dec_d;
  logic                 all_msb;
  logic [1:0]           best_d;

  // Sum is formed one bit wider so a carry out saturates instead of wrapping.
  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    sat_add = s[PM_W] ? {PM_W{1'b1}} : s[PM_W-1:0];
  endfunction

  function automatic logic [1:0] argmin(input logic [3:0][PM_W-1:0] m);
    logic [1:0]      idx;
    logic [PM_W-1:0] v;
    idx = 2'd0;
    v   = m[0];
    for (int i = 1; i < 4; i++) begin
      if (m[i] < v) begin
        v   = m[i];
        idx = 2'(i);
      end
    end
    argmin = idx;
  endfunction

  assign old_pm = (frame_start && bm_valid) ? {BIAS, BIAS, BIAS, {PM_W{1'b0}}} : pm_q;

  // Upper predecessor is the even state, lower the odd one.
  assign cand_u[0] = sat_add(old_pm[0], bm00);
  assign cand_l[0] = sat_add(old_pm[1], bm11);
  assign cand_u[1] = sat_add(old_pm[2], bm10);
  assign cand_l[1] = sat_add(old_pm[3], bm01);
  assign cand_u[2] = sat_add(old_pm[0], bm11);
  assign cand_l[2] = sat_add(old_pm[1], bm00);
  assign cand_u[3] = sat_add(old_pm[2], bm01);
  assign cand_l[3] = sat_add(old_pm[3], bm10);

  always_comb begin
    dec_d  = '0;
    raw_pm = '0;
    for (int s = 0; s < 4; s++) begin
      dec_d[s]  = (cand_l[s] < cand_u[s]);
      raw_pm[s] = dec_d[s] ? cand_l[s] : cand_u[s];
    end
  end

  assign all_msb = raw_pm[0][PM_W-1] & raw_pm[1][PM_W-1] &
                   raw_pm[2][PM_W-1] & raw_pm[3][PM_W-1];

  always_comb begin
    new_pm = raw_pm;
    if (all_msb) begin
      for (int s = 0; s < 4; s++) begin
        new_pm[s][PM_W-1] = 1'b0;
      end
    end
  end

  assign best_d = argmin(new_pm);

  always_ff @(posedge clk) begin
    if (rst) begin
      pm_q       <= {BIAS, BIAS, BIAS, {PM_W{1'b0}}};
      decisions  <= '0;
      best_state <= '0;
      dec_valid  <= 1'b0;
      norm_flag  <= 1'b0;
    end else begin
      dec_valid <= bm_valid;
      norm_flag <= bm_valid & all_msb;
      if (bm_valid) begin
        pm_q       <= new_pm;
        decisions  <= dec_d;
        best_state <= best_d;
      end
    end
  end

  assign pm0 = pm_q[0];
  assign pm1 = pm_q[1];
  assign pm2 = pm_q[2];
  assign pm3 = pm_q[3];

endmodule

// File: tb/tb_acs_4state.sv
// Randomised and directed bench for acs_4state against a trellis-level reference model.
module tb_acs_4state;

  localparam int PM_W   = 8;
  localparam int BIAS   = 16;
  localparam int PM_MAX = (1 << PM_W) - 1;
  localparam int HALF   = 1 << (PM_W - 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            bm_valid = 1'b0;
  logic            frame_start = 1'b0;
  logic [1:0]      bm00 = '0, bm01 = '0, bm10 = '0, bm11 = '0;
  logic            dec_valid;
  logic [3:0]      decisions;
  logic [PM_W-1:0] pm0, pm1, pm2, pm3;
  logic [1:0]      best_state;
  logic            norm_flag;

  acs_4state #(.PM_W(PM_W), .INIT_BIAS(BIAS)) dut (
    .clk(clk), .rst(rst), .bm_valid(bm_valid), .frame_start(frame_start),
    .bm00(bm00), .bm01(bm01), .bm10(bm10), .bm11(bm11),
    .dec_valid(dec_valid), .decisions(decisions),
    .pm0(pm0), .pm1(pm1), .pm2(pm2), .pm3(pm3),
    .best_state(best_state), .norm_flag(norm_flag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int dv_count = 0;

  // Reference state: metrics and outputs as the trellis says they should be.
  int m_pm[4];
  int m_dec, m_best, m_dv, m_nf;

  int rx[4][4] = '{'{0, 1, 1, 2}, '{2, 1, 1, 0}, '{1, 2, 0, 1}, '{1, 0, 2, 1}};
  int exp_pm[4][4] = '{'{0, 17, 2, 17}, '{2, 3, 0, 3}, '{3, 0, 3, 2}, '{1, 2, 1, 3}};
  int exp_dec[4]  = '{0, 0, 0, 7};
  int exp_best[4] = '{0, 2, 1, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Next state ns = 2*u + (ps>>1); encoder taps give c0 = u^u1^u2, c1 = u^u2.
  task automatic model(input bit r, input bit v, input bit fs, input int b0, input int b1,
                       input int b2, input int b3);
    int b[4];
    int old[4];
    int nw[4];
    int u, c0, c1, cand, best_c, sel, dec;
    bit allhi;
    b = '{b0, b1, b2, b3};
    if (r) begin
      m_pm = '{0, BIAS, BIAS, BIAS};
      m_dec = 0; m_best = 0; m_dv = 0; m_nf = 0;
      return;
    end
    m_dv = v;
    m_nf = 0;
    if (!v) return;
    for (int ps = 0; ps < 4; ps++) old[ps] = fs ? ((ps == 0) ? 0 : BIAS) : m_pm[ps];
    dec = 0;
    for (int ns = 0; ns < 4; ns++) begin
      best_c = PM_MAX + 1;
      sel = 0;
      u = ns >> 1;
      for (int ps = 0; ps < 4; ps++) begin
        if ((ps >> 1) == (ns & 1)) begin
          c0 = u ^ (ps >> 1) ^ (ps & 1);
          c1 = u ^ (ps & 1);
          cand = old[ps] + b[c0 * 2 + c1];
          if (cand > PM_MAX) cand = PM_MAX;
          if (cand < best_c) begin
            best_c = cand;
            sel = ps & 1;
          end
        end
      end
      nw[ns] = best_c;
      dec |= sel << ns;
    end
    allhi = 1'b1;
    for (int s = 0; s < 4; s++) if (nw[s] < HALF) allhi = 1'b0;
    if (allhi) begin
      for (int s = 0; s < 4; s++) nw[s] -= HALF;
      m_nf = 1;
    end
    m_pm = nw;
    m_dec = dec;
    m_best = 0;
    for (int s = 1; s < 4; s++) if (nw[s] < nw[m_best]) m_best = s;
  endtask

  task automatic cyc(input bit r, input bit v, input bit fs, input int b0, input int b1,
                     input int b2, input int b3);
    rst = r; bm_valid = v; frame_start = fs;
    bm00 = 2'(b0); bm01 = 2'(b1); bm10 = 2'(b2); bm11 = 2'(b3);
    @(posedge clk);
    #1;
    model(r, v, fs, b0, b1, b2, b3);
    if (dec_valid === 1'b1) dv_count++;
    chk("pm0", pm0, m_pm[0]);
    chk("pm1", pm1, m_pm[1]);
    chk("pm2", pm2, m_pm[2]);
    chk("pm3", pm3, m_pm[3]);
    chk("decisions", decisions, m_dec);
    chk("best_state", best_state, m_best);
    chk("dec_valid", dec_valid, m_dv);
    if (m_dv != 0) chk("norm_flag", norm_flag, m_nf);
    else chk("norm_flag_idle", norm_flag, 0);
  endtask

  task automatic idle();
    cyc(0, 0, 0, $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3));
  endtask

  initial begin
    // Reset
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_pm0", pm0, 0);
    chk("rst_pm1", pm1, 16);
    chk("rst_pm3", pm3, 16);
    chk("rst_dv", dec_valid, 0);

    // Four back-to-back steps
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, rx[i][0], rx[i][1], rx[i][2], rx[i][3]);
      chk("s2_pm0", pm0, exp_pm[i][0]);
      chk("s2_pm1", pm1, exp_pm[i][1]);
      chk("s2_pm2", pm2, exp_pm[i][2]);
      chk("s2_pm3", pm3, exp_pm[i][3]);
      chk("s2_dec", decisions, exp_dec[i]);
      chk("s2_best", best_state, exp_best[i]);
      chk("s2_dv", dec_valid, 1);
    end

    // Frame restart, then frame_start without bm_valid
    cyc(0, 1, 1, rx[0][0], rx[0][1], rx[0][2], rx[0][3]);
    chk("fs_pm1", pm1, 17);
    chk("fs_pm2", pm2, 2);
    chk("fs_dec", decisions, 0);
    cyc(0, 0, 1, 2, 2, 2, 2);
    chk("fs_idle_pm1", pm1, 17);
    chk("fs_idle_dv", dec_valid, 0);

    // Normalisation with all metrics equal to 2
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int n = 1; n <= 64; n++) begin
      cyc(0, 1, 0, 2, 2, 2, 2);
      if (n == 2) chk("norm_s2_pm2", pm2, 4);
      if (n == 63) begin
        chk("norm_s63_pm3", pm3, 126);
        chk("norm_s63_flag", norm_flag, 0);
      end
      if (n == 64) begin
        chk("norm_s64_pm0", pm0, 0);
        chk("norm_s64_pm1", pm1, 0);
        chk("norm_s64_flag", norm_flag, 1);
      end
    end
    cyc(0, 1, 0, 2, 2, 2, 2);
    chk("norm_flag_single", norm_flag, 0);

    // Valid gaps of three cycles between steps
    cyc(1, 0, 0, 0, 0, 0, 0);
    dv_count = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, rx[i][0], rx[i][1], rx[i][2], rx[i][3]);
      chk("gap_pm1", pm1, exp_pm[i][1]);
      chk("gap_dec", decisions, exp_dec[i]);
      for (int g = 0; g < 3; g++) begin
        idle();
        chk("gap_hold_pm0", pm0, exp_pm[i][0]);
      end
    end
    chk("gap_dv_count", dv_count, 4);

    // Reset colliding with step 3
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, rx[0][0], rx[0][1], rx[0][2], rx[0][3]);
    cyc(0, 1, 0, rx[1][0], rx[1][1], rx[1][2], rx[1][3]);
    cyc(1, 1, 0, rx[2][0], rx[2][1], rx[2][2], rx[2][3]);
    chk("midrst_pm0", pm0, 0);
    chk("midrst_pm2", pm2, 16);
    chk("midrst_dv", dec_valid, 0);

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      cyc(($urandom_range(99) < 2), ($urandom_range(99) < 75), ($urandom_range(99) < 8),
          $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acs_4state.md
Name: acs_4state

Overview:
- Add-compare-select stage of the rate-1/2, K=3 Viterbi decoder (generators g0=7, g1=5); sits directly downstream of the branch-metric units.
- Consumes the four 2-bit Hamming-distance branch metrics for each received symbol pair.
- Maintains the four path-metric registers and emits one survivor decision bit per state to the traceback memory, plus the current best state.

Parameters:
- PM_W, 8, path-metric width in bits (>= 6).
- INIT_BIAS, 16, initial metric of states 1..3 at reset and at frame start (< 2^(PM_W-1)).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- bm_valid  input  1  branch metrics valid this cycle; one trellis step per valid cycle.
- frame_start  input  1  qualified by bm_valid; re-initialise metrics before applying this step.
- bm00, bm01, bm10, bm11  input  2 each  distance of rx pair to codeword {c0,c1}=00/01/10/11.
- dec_valid  output  1  decisions/pm/best_state updated this cycle.
- decisions  output  4  bit s = survivor select for next state s (0 = upper predecessor, 1 = lower).
- pm0, pm1, pm2, pm3  output  PM_W each  registered path metrics.
- best_state  output  2  index of minimum registered path metric.
- norm_flag  output  1  normalisation applied on this update.

Behaviour:
- Clock and reset: one clock (clk); reset synchronous, active-high (rst).
- Reset values: pm0=0; pm1..pm3=INIT_BIAS; decisions=0; best_state=0; dec_valid=0; norm_flag=0.
- State index = 2*u[n-1] + u[n-2].
- Transitions (next state: upper pred/codeword, lower pred/codeword):
  - ns0: ps0/00, ps1/11
  - ns1: ps2/10, ps3/01
  - ns2: ps0/11, ps1/00
  - ns3: ps2/01, ps3/10
- Per step:
  - Candidate = old pm + matching bm, computed in PM_W+1 bits; clamp to 2^PM_W-1 if it overflows.
  - New pm = smaller candidate. Tie selects upper, decision 0.
- Old-metric source: if frame_start && bm_valid, the old metrics used are {0, INIT_BIAS, INIT_BIAS, INIT_BIAS}, not the registers.
- Normalisation: if all four new metrics have MSB set, clear the MSB of each before registering, and assert norm_flag for that update. No other rescaling.
- Latency: bm_valid in cycle n, then registered results plus dec_valid=1 in cycle n+1. Full throughput, one step per cycle, no back-pressure.
- best_state: computed from the newly registered metrics in the same update; lowest index wins ties.
- bm_valid=0:
  - pm, decisions and best_state hold.
  - dec_valid=0 and norm_flag=0 next cycle.
  - frame_start is ignored.
- rst mid-stream: overrides bm_valid/frame_start; all outputs return to reset values the next cycle.
- norm_flag is valid only when dec_valid=1.

Test Plan:
1. Reset: hold rst 2 cycles -> pm=0,16,16,16; decisions=0000; best_state=0; dec_valid=0; norm_flag=0.
2. From reset, feed 4 back-to-back steps {bm00,bm01,bm10,bm11} = rx 00 {0,1,1,2}, rx 11 {2,1,1,0}, rx 10 {1,2,0,1}, rx 01 {1,0,2,1}:
   - pm after each step: 0,17,2,17 -> 2,3,0,3 -> 3,0,3,2 -> 1,2,1,3.
   - decisions: 0000, 0000, 0000, 4'b0111.
   - best_state: 0, 2, 1, 0 (tie between 0 and 2 resolves to 0).
   - dec_valid high each cycle, one cycle after each input.
3. Normalisation: from reset, 64 steps with all bm=2:
   - After step 2, pm=4,4,4,4.
   - After step 63, pm=126 x4, norm_flag=0.
   - After step 64, pm=0 x4, norm_flag=1 for that single update.
4. Valid gaps: repeat scenario 2 with bm_valid low 3 cycles between steps -> identical pm/decision sequence; outputs hold during gaps; dec_valid pulses exactly 4 times.
5. Frame restart: after scenario 2, send frame_start=1, bm_valid=1 with rx 00 metrics -> pm=0,17,2,17, decisions=0000. frame_start with bm_valid=0 -> no change.
6. Reset mid-stream: assert rst in the same cycle as bm_valid during scenario 2 step 3 -> next cycle pm=0,16,16,16 and dec_valid=0; the step is discarded.
